// File: rtl/cond_flag_unit_if.sv
// Bundle of all non-clock/reset signals of cond_flag_unit.
//   master : ALU/control side. Drives flags, condition requests, acks and clears.
//   slave  : cond_flag_unit. Returns ready, the result, stored flags, v_sticky and pass_count.
interface cond_flag_unit_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             flag_we;
    logic             z_in;
    logic             n_in;
    logic             c_in;
    logic             v_in;
    logic             cond_valid;
    logic [3:0]       cond;
    logic             cond_ready;
    logic             result_valid;
    logic             result_ack;
    logic             cond_pass;
    logic             cond_illegal;
    logic [3:0]       flags;
    logic             v_sticky;
    logic             sticky_clr;
    logic [CNT_W-1:0] pass_count;
    logic             cnt_clr;

    modport master (
        output flag_we, z_in, n_in, c_in, v_in,
        output cond_valid, cond, result_ack, sticky_clr, cnt_clr,
        input  cond_ready, result_valid, cond_pass, cond_illegal,
        input  flags, v_sticky, pass_count
    );

    modport slave (
        input  flag_we, z_in, n_in, c_in, v_in,
        input  cond_valid, cond, result_ack, sticky_clr, cnt_clr,
        output cond_ready, result_valid, cond_pass, cond_illegal,
        output flags, v_sticky, pass_count
    );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural status register for the adder's N/Z/C/V flags plus a
// condition-code evaluator answering requests one cycle after acceptance.
// Also tracks a sticky overflow bit and a saturating count of passed conditions.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cond_flag_unit_if.slave (flag write, condition handshake, result,
//          stored flags, v_sticky, pass_count and their clears)
module cond_flag_unit #(
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    cond_flag_unit_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t           r_state;
    logic [3:0]       r_flags;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pass;
    logic             r_illegal;

    logic             w_ready;
    logic             w_accept;
    logic [3:0]       w_ef;
    logic             w_n, w_z, w_c, w_v;
    logic             w_pass;
    logic             w_illegal;

    // Ready depends only on state and ack so a full slot can drain and refill in one cycle.
    assign w_ready  = (r_state == ST_EMPTY) | bus.result_ack;
    assign w_accept = bus.cond_valid & w_ready;

    // Incoming flags are forwarded to a same-cycle condition when bypassing.
    assign w_ef = (BYPASS && bus.flag_we) ? {bus.n_in, bus.z_in, bus.c_in, bus.v_in} : r_flags;
    assign {w_n, w_z, w_c, w_v} = w_ef;

    // Condition code decode.
    always_comb begin
        w_pass    = 1'b0;
        w_illegal = 1'b0;
        case (bus.cond)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = ~w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = ~w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = ~w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = ~w_v;
            4'b1000: w_pass = w_c & ~w_z;
            4'b1001: w_pass = ~w_c | w_z;
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = ~w_z & (w_n == w_v);
            4'b1101: w_pass = w_z | (w_n != w_v);
            4'b1110: w_pass = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    // Flag register, sticky overflow, pass counter and result FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_flags   <= 4'b0000;
            r_sticky  <= 1'b0;
            r_cnt     <= '0;
            r_pass    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (bus.flag_we) begin
                r_flags <= {bus.n_in, bus.z_in, bus.c_in, bus.v_in};
            end
            // A V=1 write beats a simultaneous clear.
            r_sticky <= (r_sticky & ~bus.sticky_clr) | (bus.flag_we & bus.v_in);

            // Clear wins, but a passing accept in the same cycle still counts once.
            if (bus.cnt_clr) begin
                r_cnt <= (w_accept && w_pass) ? CNT_W'(1) : '0;
            end else if (w_accept && w_pass && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_pass    <= w_pass;
                        r_illegal <= w_illegal;
                        r_state   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        r_pass    <= w_pass;
                        r_illegal <= w_illegal;
                    end else if (bus.result_ack) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.cond_ready   = w_ready;
    assign bus.result_valid = (r_state == ST_FULL);
    assign bus.cond_pass    = r_pass;
    assign bus.cond_illegal = r_illegal;
    assign bus.flags        = r_flags;
    assign bus.v_sticky     = r_sticky;
    assign bus.pass_count   = r_cnt;
endmodule
